// File: rtl/mips_x_pkg.sv
// rtl/mips_x_pkg.sv - shared trap cause codes, exception field offsets and trap FSM encoding
package mips_x_pkg;

   localparam int EXC_W   = 10;
   localparam int CAUSE_W = 4;
   localparam int CNT_W   = 16;

   // Exception vector field offsets: [2:0] fetch, [3] decode, [6:4] ALU, [9:7] MEM
   localparam int EXC_FETCH_LSB  = 0;
   localparam int EXC_DECODE_LSB = 3;
   localparam int EXC_ALU_LSB    = 4;
   localparam int EXC_MEM_LSB    = 7;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 4'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_FETCH0 = 4'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_FETCH1 = 4'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_FETCH2 = 4'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_DECODE = 4'd4;
   localparam logic [CAUSE_W-1:0] CAUSE_ALU0   = 4'd5;
   localparam logic [CAUSE_W-1:0] CAUSE_ALU1   = 4'd6;
   localparam logic [CAUSE_W-1:0] CAUSE_ALU2   = 4'd7;
   localparam logic [CAUSE_W-1:0] CAUSE_MEM0   = 4'd8;
   localparam logic [CAUSE_W-1:0] CAUSE_MEM1   = 4'd9;
   localparam logic [CAUSE_W-1:0] CAUSE_MEM2   = 4'd10;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_TRAPPED = 2'd1,
      ST_FLUSH   = 2'd2
   } trap_state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - exception vector to cause code; lowest set bit wins, 0 when no bit is set
module trap_prio_enc
   import mips_x_pkg::*;
(
   input  logic [EXC_W-1:0]   exc,
   output logic [CAUSE_W-1:0] code
);

   // Scan high to low so the lowest set bit is the last to write code
   always_comb begin
      code = CAUSE_NONE;
      for (int i = EXC_W - 1; i >= 0; i--) begin
         if (exc[i]) begin
            code = CAUSE_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap capture / host restart controller; TRAP_CTRL_COUNT_EN adds the trap_count port
module trap_ctrl
   import mips_x_pkg::*;
#(
   parameter int FLUSH_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [EXC_W-1:0]   exc_in,
   input  logic               host_ack,
   output logic               core_rst,
   output logic               trapped,
   output logic [CAUSE_W-1:0] cause
`ifdef TRAP_CTRL_COUNT_EN
   ,
   output logic [CNT_W-1:0]   trap_count
`endif
);

   localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

   trap_state_t        state;
   trap_state_t        state_next;
   logic [7:0]         flush_cnt;
   logic [CAUSE_W-1:0] enc_cause;
   logic               take_trap;
   logic               start_flush;
   logic               flush_done;

   trap_prio_enc u_prio_enc (
      .exc  (exc_in),
      .code (enc_cause)
   );

   assign take_trap   = (state == ST_RUN) && (exc_in != '0);
   assign start_flush = (state == ST_TRAPPED) && host_ack;
   assign flush_done  = (state == ST_FLUSH) && (flush_cnt == 8'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // exc_in matters only in RUN and host_ack only in TRAPPED: the core is in reset elsewhere
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:     if (exc_in != '0) state_next = ST_TRAPPED;
         ST_TRAPPED: if (host_ack)     state_next = ST_FLUSH;
         ST_FLUSH:   if (flush_cnt == 8'd0) state_next = ST_RUN;
         default:    state_next = ST_RUN;
      endcase
   end

   always_comb begin
      core_rst = rst || (state != ST_RUN);
      trapped  = (state == ST_TRAPPED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt <= 8'd0;
      end else if (start_flush) begin
         flush_cnt <= FLUSH_LOAD;
      end else if ((state == ST_FLUSH) && (flush_cnt != 8'd0)) begin
         flush_cnt <= flush_cnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cause <= CAUSE_NONE;
      end else if (take_trap) begin
         cause <= enc_cause;
      end else if (flush_done) begin
         cause <= CAUSE_NONE;
      end
   end

`ifdef TRAP_CTRL_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_count <= '0;
      end else if (take_trap && (trap_count != {CNT_W{1'b1}})) begin
         trap_count <= trap_count + 1'b1;
      end
   end
`endif

endmodule
